mem_nr1w: RTL and testbench

MEM_NR1W -- requirements
Module: mem_nr1w

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_nr1w_shift.sv | 38 +++
 rtl/mem_nr1w.sv | 134 +++++++++++++
 tb/tb_mem_nr1w.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the mem_nr1w memory: FSM state encoding and init-pattern helper.
package mem_pkg;

    localparam logic [1:0] ST_RESET_ENC = 2'd0;
    localparam logic [1:0] ST_INIT_ENC  = 2'd1;
    localparam logic [1:0] ST_READY_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_RESET = ST_RESET_ENC,
        ST_INIT  = ST_INIT_ENC,
        ST_READY = ST_READY_ENC
    } mem_state_t;

    // Init value of word idx before truncation to the word width.
    function automatic int unsigned init_word(input int unsigned strt,
                                              input int unsigned incr,
                                              input int unsigned idx);
        return strt + idx * incr;
    endfunction

endpackage

// File: rtl/mem_nr1w_shift.sv
// Fixed-latency delay line; DELAY=0 is a plain wire.
module shift #(
    parameter int WIDTH = 1,
    parameter int DELAY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    generate
        if (DELAY == 0) begin : g_comb
            logic w_unused_clkrst;
            assign w_unused_clkrst = clk ^ rst;
            assign o_dout = i_din;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_pipe [DELAY];

            // Shift register, cleared on reset so no stale valids survive it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DELAY; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= i_din;
                    for (int i = 1; i < DELAY; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign o_dout = r_pipe[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/mem_nr1w.sv
// N-read / 1-write memory with optional post-reset initialisation sweep,
// configurable read latency and optional write-to-read bypass.
module mem_nr1w
    import mem_pkg::*;
#(
    parameter int NUMADDR    = 8,
    parameter int BITADDR    = 3,
    parameter int BITDATA    = 1,
    parameter int NUMRDPT    = 2,
    parameter int SRAM_DELAY = 0,
    parameter int RSTINIT    = 0,
    parameter int RSTSTRT    = 0,
    parameter int RSTINCR    = 0,
    parameter int BYPASS     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ready,
    input  logic [NUMRDPT-1:0]         read,
    input  logic [NUMRDPT*BITADDR-1:0] rd_adr,
    output logic [NUMRDPT-1:0]         rd_vld,
    output logic [NUMRDPT*BITDATA-1:0] rd_dout,
    input  logic                       write,
    input  logic [BITADDR-1:0]         wr_adr,
    input  logic [BITDATA-1:0]         wr_din
);

    localparam logic [BITADDR-1:0] LAST_ADR = BITADDR'(NUMADDR - 1);

    mem_state_t           r_state;
    logic                 r_ready;
    logic [BITADDR-1:0]   r_init_cnt;
    logic [BITDATA-1:0]   r_mem [NUMADDR];

    logic                 w_accept;
    logic                 w_wr_ok;
    logic                 w_init_wr;
    logic [BITDATA-1:0]   w_init_data;

    // Requests are honoured only in READY and never in a reset cycle.
    assign w_accept    = r_ready & ~rst;
    assign w_wr_ok     = w_accept & write & (32'(wr_adr) < 32'(NUMADDR));
    assign w_init_wr   = (r_state == ST_INIT) & ~rst;
    assign w_init_data = BITDATA'(init_word($unsigned(RSTSTRT), $unsigned(RSTINCR),
                                            32'(r_init_cnt)));
    assign ready       = w_accept;

    // Control FSM: RESET -> (INIT sweep) -> READY; ready tracks the READY state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RESET;
            r_ready    <= 1'b0;
            r_init_cnt <= '0;
        end else begin
            case (r_state)
                ST_RESET: begin
                    r_init_cnt <= '0;
                    if (RSTINIT != 0) begin
                        r_state <= ST_INIT;
                        r_ready <= 1'b0;
                    end else begin
                        r_state <= ST_READY;
                        r_ready <= 1'b1;
                    end
                end
                ST_INIT: begin
                    if (r_init_cnt == LAST_ADR) begin
                        r_state    <= ST_READY;
                        r_ready    <= 1'b1;
                        r_init_cnt <= '0;
                    end else begin
                        r_init_cnt <= r_init_cnt + BITADDR'(1);
                    end
                end
                ST_READY: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_RESET;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage array; init sweep owns the write port while in INIT. No reset so it maps to SRAM.
    always_ff @(posedge clk) begin
        if (w_init_wr) begin
            r_mem[r_init_cnt] <= w_init_data;
        end else if (w_wr_ok) begin
            r_mem[wr_adr] <= wr_din;
        end
    end

    generate
        for (genvar k = 0; k < NUMRDPT; k++) begin : g_rd
            logic [BITADDR-1:0] w_adr;
            logic               w_vld;
            logic               w_in_range;
            logic               w_hit;
            logic [BITDATA-1:0] w_data;
            logic [BITDATA:0]   w_pipe_out;
            logic               w_out_vld;

            assign w_adr      = rd_adr[k*BITADDR +: BITADDR];
            assign w_vld      = w_accept & read[k];
            assign w_in_range = 32'(w_adr) < 32'(NUMADDR);
            assign w_hit      = (BYPASS != 0) & w_wr_ok & (wr_adr == w_adr);

            // Read data select: zero when idle or out of range, forwarded on a bypass hit.
            always_comb begin
                w_data = '0;
                if (w_vld & w_in_range) begin
                    w_data = w_hit ? wr_din : r_mem[w_adr];
                end
            end

            shift #(
                .WIDTH (BITDATA + 1),
                .DELAY (SRAM_DELAY)
            ) u_shift (
                .clk    (clk),
                .rst    (rst),
                .i_din  ({w_vld, w_data}),
                .o_dout (w_pipe_out)
            );

            assign w_out_vld                     = w_pipe_out[BITDATA] & ~rst;
            assign rd_vld[k]                     = w_out_vld;
            assign rd_dout[k*BITDATA +: BITDATA] = w_out_vld ? w_pipe_out[BITDATA-1:0] : '0;
        end
    endgenerate

endmodule

// File: tb/tb_mem_nr1w.sv
// Scoreboard bench for mem_nr1w: u0 = init sweep + latency 2 + bypass,
// u1 = 6 words, latency 0, no bypass, no init.
module tb_mem_nr1w;

    typedef struct {
        logic [3:0] d;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         ntests = 0;
    int         nfail = 0;

    logic       rst0, ready0, write0;
    logic [1:0] read0, rd_vld0;
    logic [5:0] rd_adr0;
    logic [7:0] rd_dout0;
    logic [2:0] wr_adr0;
    logic [3:0] wr_din0;

    logic       rst1, ready1, write1;
    logic [1:0] read1, rd_vld1;
    logic [5:0] rd_adr1;
    logic [7:0] rd_dout1;
    logic [2:0] wr_adr1;
    logic [3:0] wr_din1;

    exp_t q00[$];
    exp_t q01[$];
    exp_t q10[$];
    exp_t q11[$];

    logic [3:0] init_exp [8];

    mem_nr1w #(
        .NUMADDR(8), .BITADDR(3), .BITDATA(4), .NUMRDPT(2), .SRAM_DELAY(2),
        .RSTINIT(1), .RSTSTRT(3), .RSTINCR(2), .BYPASS(1)
    ) u0 (
        .clk(clk), .rst(rst0), .ready(ready0), .read(read0), .rd_adr(rd_adr0),
        .rd_vld(rd_vld0), .rd_dout(rd_dout0), .write(write0), .wr_adr(wr_adr0),
        .wr_din(wr_din0)
    );

    mem_nr1w #(
        .NUMADDR(6), .BITADDR(3), .BITDATA(4), .NUMRDPT(2), .SRAM_DELAY(0),
        .RSTINIT(0), .RSTSTRT(0), .RSTINCR(0), .BYPASS(0)
    ) u1 (
        .clk(clk), .rst(rst1), .ready(ready1), .read(read1), .rd_adr(rd_adr1),
        .rd_vld(rd_vld1), .rd_dout(rd_dout1), .write(write1), .wr_adr(wr_adr1),
        .wr_din(wr_din1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int inst, input int port, input logic [3:0] d, input int c);
        exp_t e;
        e.d   = d;
        e.cyc = c;
        case (inst * 2 + port)
            0:       q00.push_back(e);
            1:       q01.push_back(e);
            2:       q10.push_back(e);
            default: q11.push_back(e);
        endcase
    endtask

    // Compare one read port against the head of its expectation queue.
    task automatic check_port(input int inst, input int port, input logic vld, input logic [3:0] d);
        exp_t e;
        bit   got;
        string tag;
        tag = $sformatf("u%0d_p%0d", inst, port);
        if (vld) begin
            got = 1'b0;
            case (inst * 2 + port)
                0:       if (q00.size() > 0) begin e = q00.pop_front(); got = 1'b1; end
                1:       if (q01.size() > 0) begin e = q01.pop_front(); got = 1'b1; end
                2:       if (q10.size() > 0) begin e = q10.pop_front(); got = 1'b1; end
                default: if (q11.size() > 0) begin e = q11.pop_front(); got = 1'b1; end
            endcase
            if (!got) begin
                ntests++;
                nfail++;
                $display("FAIL %s_unexpected_vld: got vld=1 data %0d, expected no read pending (cycle %0d)",
                         tag, d, cyc);
            end else begin
                chk({tag, "_data"}, int'(d), int'(e.d));
                chk({tag, "_latency_cycle"}, cyc, e.cyc);
            end
        end else begin
            chk({tag, "_idle_dout"}, int'(d), 0);
        end
    endtask

    // Monitor: sample all read ports mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check_port(0, k, rd_vld0[k], rd_dout0[k*4 +: 4]);
            check_port(1, k, rd_vld1[k], rd_dout1[k*4 +: 4]);
        end
    end

    task automatic clear_req();
        read0 = '0; rd_adr0 = '0; write0 = 1'b0; wr_adr0 = '0; wr_din0 = '0;
        read1 = '0; rd_adr1 = '0; write1 = 1'b0; wr_adr1 = '0; wr_din1 = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_req();
    endtask

    task automatic rd(input int inst, input int port, input logic [2:0] adr, input logic [3:0] exp);
        if (inst == 0) begin
            read0[port]          = 1'b1;
            rd_adr0[port*3 +: 3] = adr;
            push(0, port, exp, cyc + 2);
        end else begin
            read1[port]          = 1'b1;
            rd_adr1[port*3 +: 3] = adr;
            push(1, port, exp, cyc);
        end
    endtask

    task automatic wr(input int inst, input logic [2:0] adr, input logic [3:0] din);
        if (inst == 0) begin
            write0 = 1'b1; wr_adr0 = adr; wr_din0 = din;
        end else begin
            write1 = 1'b1; wr_adr1 = adr; wr_din1 = din;
        end
    endtask

    // Requests that must be ignored while u0 is not ready.
    task automatic junk_u0();
        read0 = 2'b11; rd_adr0 = {3'd7, 3'd0};
        write0 = 1'b1; wr_adr0 = 3'd0; wr_din0 = 4'hF;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        init_exp = '{4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15, 4'd1};
        rst0 = 1'b1;
        rst1 = 1'b1;
        clear_req();
        repeat (3) step();
        chk("reset_ready0", int'(ready0), 0);
        chk("reset_ready1", int'(ready1), 0);

        // Requests during reset are ignored.
        junk_u0();
        read1 = 2'b11;
        #1;
        chk("reset_rd_vld1", int'(rd_vld1), 0);
        step();

        // u0: release, abort the sweep at INIT cycle 4, release again.
        rst0 = 1'b0;
        step();
        chk("init1_entry_ready0", int'(ready0), 0);
        for (int i = 0; i < 4; i++) begin
            junk_u0();
            step();
            chk("init1_ready0", int'(ready0), 0);
        end
        rst0 = 1'b1;
        step();
        chk("midinit_rst_ready0", int'(ready0), 0);
        rst0 = 1'b0;
        step();
        chk("init2_entry_ready0", int'(ready0), 0);
        for (int i = 0; i < 7; i++) begin
            junk_u0();
            step();
            chk("init2_ready0", int'(ready0), 0);
        end
        junk_u0();
        step();
        chk("init2_done_ready0", int'(ready0), 1);

        // Initial contents 3 + 2i mod 16 on both ports.
        for (int j = 0; j < 4; j++) begin
            rd(0, 0, 3'(2 * j), init_exp[2 * j]);
            rd(0, 1, 3'(2 * j + 1), init_exp[2 * j + 1]);
            step();
        end

        // Write then read next cycle, both ports on the same address.
        wr(0, 3'd5, 4'hA);
        step();
        rd(0, 1, 3'd5, 4'hA);
        rd(0, 0, 3'd5, 4'hA);
        step();

        // Same-cycle write/read with bypass.
        wr(0, 3'd2, 4'h9);
        step();
        wr(0, 3'd2, 4'h5);
        rd(0, 0, 3'd2, 4'h5);
        step();
        rd(0, 1, 3'd2, 4'h5);
        rd(0, 0, 3'd7, 4'd1);
        step();
        repeat (3) step();

        // u1: the RESET cycle after release ignores requests.
        rst1 = 1'b0;
        read1 = 2'b11;
        #1;
        chk("u1_reset_cycle_ready", int'(ready1), 0);
        chk("u1_reset_cycle_vld", int'(rd_vld1), 0);
        step();
        chk("u1_ready", int'(ready1), 1);

        // Same-cycle write/read without bypass returns old data.
        wr(1, 3'd2, 4'h9);
        step();
        wr(1, 3'd2, 4'h5);
        rd(1, 0, 3'd2, 4'h9);
        step();
        rd(1, 1, 3'd2, 4'h5);
        rd(1, 0, 3'd2, 4'h5);
        step();

        // Out-of-range write dropped, out-of-range reads return 0.
        wr(1, 3'd1, 4'h4);
        step();
        wr(1, 3'd7, 4'hF);
        step();
        rd(1, 0, 3'd7, 4'h0);
        rd(1, 1, 3'd6, 4'h0);
        step();
        rd(1, 0, 3'd1, 4'h4);
        step();
        wr(1, 3'd5, 4'h3);
        step();
        rd(1, 1, 3'd5, 4'h3);
        step();

        // Reset with a read pending: no valid, ready low, contents kept.
        rst1 = 1'b1;
        read1 = 2'b01;
        rd_adr1 = {3'd0, 3'd2};
        #1;
        chk("u1_rst_vld", int'(rd_vld1), 0);
        chk("u1_rst_ready", int'(ready1), 0);
        chk("u1_rst_dout", int'(rd_dout1), 0);
        step();
        rst1 = 1'b0;
        step();
        chk("u1_rerelease_ready", int'(ready1), 1);
        rd(1, 0, 3'd2, 4'h5);
        step();

        repeat (4) step();
        chk("scoreboard_drained", q00.size() + q01.size() + q10.size() + q11.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
